// File: rtl/core_pkg.sv
// Shared fetch-side definitions: branch select encodings, the canonical NOP
// and the fetch state encoding.
package core_pkg;

  localparam logic [1:0]  BSEL_SEQ  = 2'b00;
  localparam logic [1:0]  BSEL_BR   = 2'b01;
  localparam logic [1:0]  BSEL_JMP  = 2'b10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  // Either jump encoding (10 or 11) selects the jump target.
  function automatic logic is_jump(input logic [1:0] sel);
    return (sel & BSEL_JMP) != 2'b00;
  endfunction

endpackage

// File: rtl/if_buffer.sv
// Single-entry fetch buffer holding the instruction (or fault) handed to decode.
// A load wins over flush and drain in the same cycle.
module if_buffer
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic [XLEN-1:0] load_instr_i,
  input  logic            load_misalign_i,
  input  logic            flush_i,
  input  logic            drain_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            misalign_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= XLEN'(NOP_INSTR);
      misalign_q <= 1'b0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      pc_q       <= load_pc_i;
      instr_q    <= load_instr_i;
      misalign_q <= load_misalign_i;
    end else if (flush_i || drain_i) begin
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign instr_o    = instr_q;
  assign misalign_o = misalign_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch handshake.
// state  | meaning
// S_REQ  | request presented at pc, waiting for grant
// S_WAIT | granted, waiting for read data (or holding it pending buffer space)
// S_HALT | misaligned redirect taken, idle until an aligned redirect
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      branch_sel,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic            dec_ready,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_misalign
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            pend_q, pend_d;
  logic [XLEN-1:0] pend_data_q, pend_data_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            stale;
  logic            resp_valid;
  logic [XLEN-1:0] resp_data;
  logic            can_load;

  logic            buf_load;
  logic [XLEN-1:0] buf_pc;
  logic [XLEN-1:0] buf_instr;
  logic            buf_misalign;
  logic            buf_flush;

  assign redirect   = redirect_valid && (branch_sel != BSEL_SEQ);
  assign target     = is_jump(branch_sel) ? jump_target : branch_target;
  assign misalign   = target[1:0] != 2'b00;
  assign resp_valid = imem_rvalid || pend_q;
  assign resp_data  = pend_q ? pend_data_q : imem_rdata;
  assign can_load   = !if_valid || dec_ready;

  // A response still in flight after a redirect targets the old PC and must be dropped.
  always_comb begin
    stale = 1'b0;
    case (state_q)
      S_REQ:   stale = imem_gnt;
      S_WAIT:  stale = !resp_valid;
      S_HALT:  stale = drop_q && !imem_rvalid;
      default: stale = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    pend_d       = pend_q;
    pend_data_d  = pend_data_q;
    buf_load     = 1'b0;
    buf_pc       = pc_q;
    buf_instr    = resp_data;
    buf_misalign = 1'b0;
    buf_flush    = 1'b0;
    if (redirect) begin
      pc_d      = target;
      pend_d    = 1'b0;
      buf_flush = 1'b1;
      drop_d    = stale;
      if (misalign) begin
        buf_load     = 1'b1;
        buf_pc       = target;
        buf_instr    = XLEN'(NOP_INSTR);
        buf_misalign = 1'b1;
        state_d      = S_HALT;
      end else begin
        state_d = stale ? S_WAIT : S_REQ;
      end
    end else begin
      case (state_q)
        S_REQ: if (imem_gnt) state_d = S_WAIT;
        S_WAIT: begin
          if (resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (can_load) begin
              buf_load = 1'b1;
              pc_d     = pc_q + XLEN'(4);
              pend_d   = 1'b0;
              state_d  = S_REQ;
            end else begin
              pend_d      = 1'b1;
              pend_data_d = resp_data;
            end
          end
        end
        S_HALT: if (imem_rvalid) drop_d = 1'b0;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign imem_req  = rst_n && (state_q == S_REQ);
  assign imem_addr = pc_q;

  if_buffer #(.XLEN(XLEN)) u_if_buffer (
    .clk             (clk),
    .rst_n           (rst_n),
    .load_i          (buf_load),
    .load_pc_i       (buf_pc),
    .load_instr_i    (buf_instr),
    .load_misalign_i (buf_misalign),
    .flush_i         (buf_flush),
    .drain_i         (if_valid && dec_ready),
    .valid_o         (if_valid),
    .pc_o            (if_pc),
    .instr_o         (if_instr),
    .misalign_o      (if_misalign)
  );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a small instruction memory model
// whose response latency is adjustable per scenario.
module tb_pc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  branch_sel;
  logic        redirect_valid;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        dec_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misalign;

  int checks = 0;
  int failures = 0;

  logic        gnt_en;
  int          lat;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_sel     (branch_sel),
    .redirect_valid (redirect_valid),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .dec_ready      (dec_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_misalign    (if_misalign)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_gnt = imem_req && gnt_en;

  // lat = extra wait cycles beyond the minimum one-cycle response.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_busy    <= 1'b0;
      mem_cnt     <= 0;
      mem_addr    <= '0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= 1'b0;
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(mem_addr);
          mem_busy    <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end else if (imem_req && imem_gnt) begin
        if (lat == 0) begin
          imem_rvalid <= 1'b1;
          imem_rdata  <= mem_word(imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= lat;
          mem_addr <= imem_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!if_valid && n < 20);
    chk({tag, "_valid"}, 32'(if_valid), 32'd1);
    chk({tag, "_pc"}, if_pc, exp_pc);
    chk({tag, "_instr"}, if_instr, mem_word(exp_pc));
    chk({tag, "_mis"}, 32'(if_misalign), 32'd0);
  endtask

  task automatic redir(input logic [1:0] sel, input logic [31:0] tgt);
    redirect_valid = 1'b1;
    branch_sel     = sel;
    branch_target  = tgt;
    jump_target    = tgt;
  endtask

  task automatic redir_off();
    redirect_valid = 1'b0;
    branch_sel     = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    rst_n          = 1'b0;
    branch_sel     = 2'b00;
    redirect_valid = 1'b0;
    branch_target  = '0;
    jump_target    = '0;
    dec_ready      = 1'b1;
    gnt_en         = 1'b1;
    lat            = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_mis", 32'(if_misalign), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    rst_n = 1'b1;

    // Sequential fetches at 0x0, 0x4
    wait_valid(32'h0, "seq0");
    wait_valid(32'h4, "seq4");
    chk("seq8_addr", imem_addr, 32'h8);
    chk("seq8_req", 32'(imem_req), 32'd1);

    // Branch redirect while 0x8 is outstanding
    lat = 2;
    step();
    redir(2'b01, 32'h100);
    step();
    redir_off();
    chk("br_valid", 32'(if_valid), 32'd0);
    chk("br_req", 32'(imem_req), 32'd0);
    step();
    step();
    chk("br_req2", 32'(imem_req), 32'd1);
    chk("br_addr", imem_addr, 32'h100);
    lat = 0;
    wait_valid(32'h100, "br");

    // Jump in the same cycle as the response
    step();
    redir(2'b11, 32'h40);
    step();
    redir_off();
    chk("jmp_valid", 32'(if_valid), 32'd0);
    chk("jmp_req", 32'(imem_req), 32'd1);
    chk("jmp_addr", imem_addr, 32'h40);
    wait_valid(32'h40, "jmp");

    // Misaligned jump, then aligned branch out of halt
    redir(2'b10, 32'h42);
    dec_ready = 1'b0;
    step();
    redir_off();
    chk("mis_valid", 32'(if_valid), 32'd1);
    chk("mis_flag", 32'(if_misalign), 32'd1);
    chk("mis_pc", if_pc, 32'h42);
    chk("mis_instr", if_instr, NOP);
    chk("mis_req", 32'(imem_req), 32'd0);
    dec_ready = 1'b1;
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (imem_req) reqs++;
    end
    chk("halt_reqs", 32'(reqs), 32'd0);
    chk("halt_drained", 32'(if_valid), 32'd0);
    redir(2'b01, 32'h200);
    step();
    redir_off();
    chk("unhalt_req", 32'(imem_req), 32'd1);
    chk("unhalt_addr", imem_addr, 32'h200);
    chk("unhalt_mis", 32'(if_misalign), 32'd0);
    wait_valid(32'h200, "unhalt");

    // Decode stall with buffer full
    dec_ready = 1'b0;
    step();
    reqs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (imem_req && imem_gnt) reqs++;
      chk("stall_pc", if_pc, 32'h200);
      chk("stall_instr", if_instr, mem_word(32'h200));
    end
    chk("stall_gnts", 32'(reqs), 32'd0);
    dec_ready = 1'b1;
    step();
    chk("unstall_valid", 32'(if_valid), 32'd1);
    chk("unstall_pc", if_pc, 32'h204);
    chk("unstall_instr", if_instr, mem_word(32'h204));

    // Wrap from 0xFFFF_FFFC
    redir(2'b11, 32'hFFFF_FFFC);
    step();
    redir_off();
    chk("wrap_flush", 32'(if_valid), 32'd0);
    wait_valid(32'hFFFF_FFFC, "wrap");
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", 32'(imem_req), 32'd1);

    // Reset in the middle of a transaction
    lat = 2;
    step();
    rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(imem_req), 32'd0);
    chk("mrst_valid", 32'(if_valid), 32'd0);
    step();
    chk("mrst_req2", 32'(imem_req), 32'd0);
    lat = 0;
    rst_n = 1'b1;
    #1;
    chk("mrst_addr", imem_addr, 32'h0);
    chk("mrst_req3", 32'(imem_req), 32'd1);
    @(negedge clk);
    wait_valid(32'h0, "mrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and the instruction-fetch handshake for the RV32I core.
- Consumes branch_sel from the branch control unit, together with the branch and jump targets computed in execute.
- Issues word fetches to instruction memory, one outstanding request at a time.
- Presents a single-entry buffered instruction and its PC to decode.

Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- XLEN, 32: address and data width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- branch_sel  in  2  from branch control unit: 00 sequential, 01 branch taken, 1x jump.
- redirect_valid  in  1  qualifies branch_sel; execute holds a valid control-flow instruction this cycle.
- branch_target  in  XLEN  PC+imm for a taken branch.
- jump_target  in  XLEN  JAL/JALR target, with bit 0 already cleared.
- dec_ready  in  1  decode accepts the buffered instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  XLEN  fetch address, equal to the PC.
- imem_gnt  in  1  request accepted.
- imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_gnt.
- imem_rdata  in  XLEN  instruction word.
- if_valid  out  1  buffer holds an instruction or a fault.
- if_pc  out  XLEN  PC of the buffered entry.
- if_instr  out  XLEN  buffered instruction word.
- if_misalign  out  1  buffered entry is an instruction-address-misaligned fault.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - pc=RESET_PC, state=S_REQ, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), if_misalign=0.
  - imem_req=0 while rst_n=0; drop flag cleared.
- State machine:
  - S_REQ: imem_req=1, imem_addr=pc. On imem_gnt go to S_WAIT. imem_req and imem_addr must stay stable until imem_gnt.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - If drop=1: discard the data, clear drop, go to S_REQ.
    - Otherwise: load the buffer (if_instr=imem_rdata, if_pc=pc, if_valid=1), set pc=pc+4 with modulo 2^32 wrap, go to S_REQ.
    - The capture is legal only if the buffer is empty or is being drained by dec_ready this cycle. Otherwise hold in S_WAIT with data pending and re-sample on the next cycle.
  - S_HALT: entered after a misaligned redirect. No requests issued. Left only by the next aligned redirect.
- Buffer drain: if_valid=1 and dec_ready=1 clears if_valid, unless a new capture occurs in the same cycle. Throughput is 1 instruction per 2 cycles with single-cycle memory.
- Redirect (redirect_valid=1 and branch_sel!=00):
  - target = branch_target if branch_sel=01; target = jump_target if branch_sel[1]=1.
  - Redirect has priority over every other event in the same cycle.
  - Clears if_valid, since the younger instruction is squashed, and sets pc=target.
  - Issued in S_WAIT with response not yet returned: set drop=1 and stay in S_WAIT.
  - Issued in S_WAIT in the same cycle as imem_rvalid: discard the data and go to S_REQ.
  - Issued in S_REQ: the new address is presented next cycle. A grant in the redirect cycle is treated as targeting the old PC, so set drop=1 and go to S_WAIT.
- Misaligned target (target[1:0]!=00):
  - Set if_valid=1, if_misalign=1, if_pc=target, if_instr=NOP; go to S_HALT.
  - dec_ready drains the fault entry like a normal entry.
- redirect_valid=1 with branch_sel=00 has no effect.
- Reset mid-transaction: state returns to S_REQ and a late imem_rvalid is ignored. Memory is reset on the same rst_n.

Decomposition:
- Shared package core_pkg:
  - branch_sel encodings BSEL_SEQ=2'b00, BSEL_BR=2'b01, BSEL_JMP=2'b10/2'b11.
  - NOP_INSTR=32'h0000_0013.
  - Fetch state enum (S_REQ, S_WAIT, S_HALT).
- One natural sub-module, if_buffer: the single-entry valid/pc/instr/misalign register with load, drain and flush controls.
- The FSM and PC register stay in pc_fetch_unit.

Test Plan:
- Reset release, memory with 1-cycle rvalid, dec_ready=1: fetches at 0x0, 0x4, 0x8. if_pc values 0x0, 0x4, 0x8, each with if_valid pulsing 1.
- branch_sel=01, branch_target=0x100, redirect_valid=1 while in S_WAIT for 0x8: the 0x8 response is dropped, if_valid=0, next imem_addr=0x100, next if_pc=0x100.
- branch_sel=11, jump_target=0x40, redirect_valid=1 in the same cycle as imem_rvalid: the data is discarded, next request is at 0x40.
- jump_target=0x42: if_valid=1, if_misalign=1, if_pc=0x42; no further imem_req until a redirect to 0x200, which then fetches 0x200.
- dec_ready=0 for 5 cycles with the buffer full: if_pc and if_instr are stable, at most one pending response is held, and no new imem_req is granted. When dec_ready rises, the next if_pc is +4.
- PC=0xFFFF_FFFC sequential fetch: the next imem_addr wraps to 0x0. An rst_n pulse in S_WAIT leaves imem_req=0 during reset and the first fetch after release is RESET_PC.
